uart_rx_framer: RTL and testbench
=================================

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, number of stop bits, legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries, power of two, at least 2.
REQ-007 SHALL have port clk, input, 1, single clock, rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-009 SHALL have port RsRx, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port data_out, output, DATA_BITS, head-of-FIFO word.
REQ-011 SHALL have port data_valid, output, 1, FIFO not empty.
REQ-012 SHALL have port data_ready, input, 1, consumer accepts the head word.
REQ-013 SHALL have port parity_err, output, 1, sticky parity error.
REQ-014 SHALL have port frame_err, output, 1, sticky framing error.
REQ-015 SHALL have port overrun, output, 1, sticky FIFO overrun.
REQ-016 SHALL have port clear_err, input, 1, one-cycle pulse that clears all sticky flags.
REQ-017 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, number of stored words.
REQ-018 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-019 SHALL pass RsRx through a two-flop synchronizer; all sampling uses the synchronized value.
REQ-020 SHALL generate a one-cycle oversample tick every DIV = CLOCK_RATE/(BAUD_RATE*16) clocks (integer floor; 651 at the defaults).
REQ-021 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-022 IDLE: a high-to-low transition on the synchronized line SHALL move the FSM to START and restart the tick divider and tick counter.
REQ-023 START: at tick 8, a low line SHALL move the FSM to DATA; a high line (false start) SHALL return it to IDLE with no flag set.
REQ-024 DATA: SHALL sample one bit every 16 ticks, LSB first, DATA_BITS bits, then go to PARITY if PARITY != 0, otherwise to STOP.
REQ-025 PARITY: SHALL sample one bit 16 ticks later; a mismatch against odd or even parity over the data bits SHALL mark the frame parity-bad.
REQ-026 STOP: SHALL sample STOP_BITS bits at 16-tick spacing; any low stop sample SHALL mark the frame frame-bad.
REQ-027 At the final stop sample, a good frame SHALL be pushed into the FIFO on that cycle and the FSM SHALL return to IDLE.
REQ-028 A bad frame SHALL NOT be pushed; the corresponding sticky flag(s) SHALL be set on that cycle.
REQ-029 A frame-bad frame with all data bits zero (break) SHALL move the FSM to BREAK, which SHALL hold until the line is high, then go to IDLE.
REQ-030 FIFO SHALL be first-word-fall-through: data_valid is high iff fifo_count != 0, and data_out holds the oldest word.
REQ-031 A pop SHALL occur on a cycle with data_valid && data_ready; a pop while empty SHALL be ignored.
REQ-032 data_valid SHALL rise on the cycle after the push cycle.
REQ-033 A push while full SHALL drop the word and set overrun, except when a pop occurs on the same cycle, in which case the push SHALL be accepted and fifo_count SHALL stay unchanged.
REQ-034 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-035 clear_err SHALL clear parity_err, frame_err and overrun on the next edge; if a set event coincides with clear_err, set SHALL win.

Reset
REQ-036 reset low at a rising edge SHALL, on that edge, put the FSM in IDLE, empty the FIFO, reset the divider and the synchronizer to 1, and drive data_valid=0, fifo_count=0, busy=0, parity_err=0, frame_err=0, overrun=0 and data_out=0.
REQ-037 reset asserted mid-frame SHALL abandon the frame with no push; after release, a low line SHALL NOT be treated as a start until a high-to-low transition occurs.

Verification (bench uses CLOCK_RATE=1_600_000, BAUD_RATE=10_000, so DIV=10 and one bit = 160 clk)
REQ-038 8N1, send 0xA5 with data_ready=0 -> data_valid rises, data_out=0xA5, fifo_count=1, all flags 0.
REQ-039 8E1, send 0x03 with parity bit 1 -> no push, parity_err=1; then pulse clear_err -> parity_err=0.
REQ-040 8N2, send 0x55 with second stop bit low -> frame_err=1, fifo_count unchanged.
REQ-041 FIFO_DEPTH=4, data_ready=0, send 5 frames 0x01..0x05 -> fifo_count=4, overrun=1; popping yields 0x01..0x04.
REQ-042 Line held low for 40 bit times -> frame_err=1, FSM stays in BREAK with busy=1; after the line returns high, send 0x7E -> received correctly.
REQ-043 Low glitch of 50 clk on an idle line -> false start, no push, no flags; then assert reset mid-frame of 0x33 -> fifo_count=0, no push after release.

Source files
------------

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: 16x-oversampled UART receiver with parity/stop checking, break detect and FWFT receive FIFO
module uart_rx_framer #(
   parameter int CLOCK_RATE = 100_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          RsRx,
   output logic [DATA_BITS-1:0]          data_out,
   output logic                          data_valid,
   input  logic                          data_ready,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          clear_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy
);
   localparam int DIV = CLOCK_RATE / (BAUD_RATE * 16);
   localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PAR = 3'd3, S_STOP = 3'd4, S_BRK = 3'd5;
   logic [1:0] sync, settle;
   logic hi_q;
   logic [2:0] state;
   logic [DW-1:0] cnt;
   logic [3:0] tc, bc;
   logic [DATA_BITS-1:0] sh;
   logic pbad, fbad;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic rx, fall, tick, samp, last_stop, fb_now, push_req, full, pop, push;
   assign rx        = sync[1];
   assign fall      = hi_q & ~rx;
   assign tick      = cnt == DW'(DIV - 1);
   assign samp      = tick && tc == 4'hf;
   assign last_stop = state == S_STOP && samp && bc == 4'(STOP_BITS - 1);
   assign fb_now    = fbad | ~rx;
   assign push_req  = last_stop & ~fb_now & ~pbad;
   assign full      = fifo_count == (AW+1)'(FIFO_DEPTH);
   assign pop       = data_valid & data_ready;
   assign push      = push_req & (~full | pop);
   assign data_valid = fifo_count != '0;
   assign data_out  = data_valid ? mem[rp] : '0;
   assign busy      = state != S_IDLE;
   // hi_q only reports a real high once the synchronizer holds line data, so a line low at reset release is not a start
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync   <= 2'b11;
         settle <= 2'b00;
         hi_q   <= 1'b0;
      end else begin
         sync   <= {sync[0], RsRx};
         settle <= {settle[0], 1'b1};
         hi_q   <= settle[1] & sync[1];
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         tc    <= '0;
         bc    <= '0;
         sh    <= '0;
         pbad  <= 1'b0;
         fbad  <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) tc <= tc + 1'b1;
         case (state)
            S_IDLE: if (fall) begin
               state <= S_START;
               cnt   <= '0;
               tc    <= '0;
               bc    <= '0;
               pbad  <= 1'b0;
               fbad  <= 1'b0;
            end
            S_START: if (tick && tc == 4'd7) begin
               tc    <= '0;
               state <= rx ? S_IDLE : S_DATA;
            end
            S_DATA: if (samp) begin
               sh <= {rx, sh[DATA_BITS-1:1]};
               bc <= bc + 1'b1;
               if (bc == 4'(DATA_BITS - 1)) begin
                  bc    <= '0;
                  state <= PARITY != 0 ? S_PAR : S_STOP;
               end
            end
            S_PAR: if (samp) begin
               pbad  <= ^sh ^ rx ^ (PARITY == 1);
               state <= S_STOP;
            end
            S_STOP: if (samp) begin
               fbad <= fb_now;
               bc   <= bc + 1'b1;
               if (last_stop) state <= (fb_now && sh == '0) ? S_BRK : S_IDLE;
            end
            S_BRK: if (rx) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= sh;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         wp         <= '0;
         rp         <= '0;
         fifo_count <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         parity_err <= (last_stop & pbad) | (parity_err & ~clear_err);
         frame_err  <= (last_stop & fb_now) | (frame_err & ~clear_err);
         overrun    <= (push_req & full & ~pop) | (overrun & ~clear_err);
      end
   end
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: three receiver configurations (8N1, 8E1, 8N2, depth 4) driven by a bit-level serial sender
module tb_uart_rx_framer;
   logic clk = 1'b0, reset = 1'b0, clear_err = 1'b0;
   logic [2:0] rx = 3'b111, rdy = 3'b000;
   logic [2:0] dv, pe, fe, ov, bz;
   logic [7:0] dout [3];
   logic [2:0] cnt [3];
   int checks = 0, failures = 0;
   typedef struct {
      int u;
      logic [7:0] d;
      logic pbit;
      logic [1:0] stops;
      logic push;
      logic epe;
      logic efe;
   } vec_t;
   vec_t tbl [10];
   logic [7:0] q [$];
   always #5 clk = ~clk;
   uart_rx_framer #(.CLOCK_RATE(1_600_000), .BAUD_RATE(10_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .reset(reset), .RsRx(rx[0]), .data_out(dout[0]), .data_valid(dv[0]), .data_ready(rdy[0]),
      .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .clear_err(clear_err), .fifo_count(cnt[0]), .busy(bz[0]));
   uart_rx_framer #(.CLOCK_RATE(1_600_000), .BAUD_RATE(10_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .reset(reset), .RsRx(rx[1]), .data_out(dout[1]), .data_valid(dv[1]), .data_ready(rdy[1]),
      .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .clear_err(clear_err), .fifo_count(cnt[1]), .busy(bz[1]));
   uart_rx_framer #(.CLOCK_RATE(1_600_000), .BAUD_RATE(10_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
      .clk(clk), .reset(reset), .RsRx(rx[2]), .data_out(dout[2]), .data_valid(dv[2]), .data_ready(rdy[2]),
      .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .clear_err(clear_err), .fifo_count(cnt[2]), .busy(bz[2]));
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic bit_out(input int u, input logic v);
      rx[u] = v;
      repeat (160) @(negedge clk);
   endtask
   // u1 carries a parity bit, u2 carries a second stop bit; two idle bit times follow every frame
   task automatic send(input int u, input logic [7:0] d, input logic pbit, input logic [1:0] stops);
      bit_out(u, 1'b0);
      for (int i = 0; i < 8; i++) bit_out(u, d[i]);
      if (u == 1) bit_out(u, pbit);
      bit_out(u, stops[0]);
      if (u == 2) bit_out(u, stops[1]);
      bit_out(u, 1'b1);
      bit_out(u, 1'b1);
   endtask
   task automatic pop(input int u);
      rdy[u] = 1'b1;
      @(negedge clk);
      rdy[u] = 1'b0;
   endtask
   task automatic pulse_clear();
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      @(negedge clk);
   endtask
   initial begin
      logic [7:0] d;
      logic good;
      bit ovm, fem;
      int np;
      tbl[0] = '{1, 8'h03, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1, 8'h03, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{1, 8'h07, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1, 8'h07, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1, 8'h80, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{1, 8'h81, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1};
      tbl[6] = '{2, 8'h55, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{2, 8'h55, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1};
      tbl[8] = '{2, 8'hAA, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1};
      tbl[9] = '{2, 8'h00, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0};
      repeat (4) @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         chk($sformatf("reset u%0d valid", u), dv[u], 0);
         chk($sformatf("reset u%0d count", u), cnt[u], 0);
         chk($sformatf("reset u%0d busy", u), bz[u], 0);
         chk($sformatf("reset u%0d flags", u), {pe[u], fe[u], ov[u]}, 0);
         chk($sformatf("reset u%0d data", u), dout[u], 0);
      end
      reset = 1'b1;
      repeat (10) @(negedge clk);
      send(0, 8'hA5, 1'b0, 2'b11);
      chk("8N1 A5 valid", dv[0], 1);
      chk("8N1 A5 data", dout[0], 8'hA5);
      chk("8N1 A5 count", cnt[0], 1);
      chk("8N1 A5 flags", {pe[0], fe[0], ov[0]}, 0);
      pop(0);
      chk("8N1 A5 popped count", cnt[0], 0);
      for (int i = 0; i < 10; i++) begin
         send(tbl[i].u, tbl[i].d, tbl[i].pbit, tbl[i].stops);
         chk($sformatf("vec%0d count", i), cnt[tbl[i].u], {2'b00, tbl[i].push});
         chk($sformatf("vec%0d parity_err", i), pe[tbl[i].u], tbl[i].epe);
         chk($sformatf("vec%0d frame_err", i), fe[tbl[i].u], tbl[i].efe);
         if (tbl[i].push) begin
            chk($sformatf("vec%0d data", i), dout[tbl[i].u], tbl[i].d);
            pop(tbl[i].u);
         end
         pulse_clear();
         chk($sformatf("vec%0d cleared", i), {pe[tbl[i].u], fe[tbl[i].u]}, 0);
      end
      for (int v = 1; v <= 5; v++) send(0, 8'(v), 1'b0, 2'b11);
      chk("overflow count", cnt[0], 4);
      chk("overflow overrun", ov[0], 1);
      chk("overflow frame_err", fe[0], 0);
      for (int v = 1; v <= 4; v++) begin
         chk($sformatf("overflow pop%0d", v), dout[0], v);
         pop(0);
      end
      chk("overflow drained", {dv[0], cnt[0]}, 0);
      pulse_clear();
      chk("overrun cleared", ov[0], 0);
      rx[0] = 1'b0;
      repeat (40 * 160) @(negedge clk);
      chk("break frame_err", fe[0], 1);
      chk("break busy", bz[0], 1);
      chk("break no push", cnt[0], 0);
      rx[0] = 1'b1;
      repeat (20) @(negedge clk);
      chk("break released busy", bz[0], 0);
      pulse_clear();
      send(0, 8'h7E, 1'b0, 2'b11);
      chk("after break data", dout[0], 8'h7E);
      chk("after break count", cnt[0], 1);
      chk("after break flags", {pe[0], fe[0], ov[0]}, 0);
      pop(0);
      ovm = 0;
      fem = 0;
      for (int i = 0; i < 10; i++) begin
         d = 8'($urandom);
         good = $urandom_range(0, 3) != 0;
         send(0, d, 1'b0, {1'b1, good});
         if (good) begin
            if (q.size() < 4) q.push_back(d);
            else ovm = 1;
         end else fem = 1;
         chk($sformatf("rand%0d count", i), cnt[0], q.size());
         chk($sformatf("rand%0d overrun", i), ov[0], ovm);
         chk($sformatf("rand%0d frame_err", i), fe[0], fem);
         np = $urandom_range(0, 2);
         for (int k = 0; k < np && q.size() > 0; k++) begin
            chk($sformatf("rand%0d pop%0d", i, k), dout[0], q.pop_front());
            pop(0);
         end
         chk($sformatf("rand%0d count after pops", i), cnt[0], q.size());
      end
      while (q.size() > 0) begin
         chk("rand drain", dout[0], q.pop_front());
         pop(0);
      end
      pulse_clear();
      rx[0] = 1'b0;
      repeat (50) @(negedge clk);
      rx[0] = 1'b1;
      repeat (300) @(negedge clk);
      chk("glitch busy", bz[0], 0);
      chk("glitch count", cnt[0], 0);
      chk("glitch flags", {pe[0], fe[0], ov[0]}, 0);
      bit_out(0, 1'b0);
      bit_out(0, 1'b1);
      bit_out(0, 1'b1);
      rx[0] = 1'b0;
      repeat (60) @(negedge clk);
      chk("mid-frame busy before reset", bz[0], 1);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid-frame reset busy", bz[0], 0);
      chk("mid-frame reset count", cnt[0], 0);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      chk("low line after reset busy", bz[0], 0);
      repeat (60) @(negedge clk);
      rx[0] = 1'b1;
      repeat (1600) @(negedge clk);
      chk("after reset count", cnt[0], 0);
      chk("after reset busy", bz[0], 0);
      chk("after reset flags", {pe[0], fe[0], ov[0]}, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
